x_stack: RTL and testbench

- LIFO value stack serving the CPU's `PUSH X/Y` and `POP X/Y` instructions.
- It sits on the responder side of the CPU stack interface: it accepts pushes from `stack_out`/`stack_out_valid` and presents the top of stack on `stack_in`/`stack_in_valid`.
- Top of stack (TOS) is held in a register. Deeper entries live in a synchronous-read RAM, so a pop costs one refill bubble.

---
 rtl/x_stack_pkg.sv | 9 +
 rtl/x_stack_ram.sv | 25 ++
 rtl/x_stack.sv | 92 +++++++++
 tb/tb_x_stack.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_stack_pkg.sv
// Shared types for the x_stack LIFO: the refill state machine encoding.
package x_stack_pkg;

    typedef enum logic {
        READY  = 1'b0,
        REFILL = 1'b1
    } x_stack_state_t;

endpackage

// File: rtl/x_stack_ram.sv
// Backing store for every stack entry below TOS. Single port, registered read.
module x_stack_ram #(
    parameter int X_SIZE = 1024,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk_in,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [X_SIZE-1:0] wdata,
    output logic [X_SIZE-1:0] rdata
);

    logic [X_SIZE-1:0] mem [0:DEPTH-2];

    // The controller never asserts we and re together, so ordering does not matter.
    always_ff @(posedge clk_in) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/x_stack.sv
// LIFO value stack for PUSH/POP X/Y: TOS held in a register, deeper entries in RAM.
// A pop from two or more entries spends one REFILL cycle reloading TOS from RAM.
module x_stack
    import x_stack_pkg::*;
#(
    parameter int X_SIZE = 1024,
    parameter int DEPTH  = 64,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [X_SIZE-1:0] push_data_in,
    input  logic              push_valid_in,
    output logic              push_ready_out,
    output logic [X_SIZE-1:0] top_out,
    output logic              top_valid_out,
    input  logic              pop_ready_in,
    output logic [CW-1:0]     count_out,
    output logic              underflow_out
);

    x_stack_state_t    state;
    logic [CW-1:0]     count;
    logic [X_SIZE-1:0] tos;
    logic              underflow;

    logic              push_fire;
    logic              pop_fire;
    logic              ram_we;
    logic              ram_re;
    logic [AW-1:0]     sp;
    logic [AW-1:0]     ram_addr;
    logic [X_SIZE-1:0] ram_rdata;

    // Handshake outputs depend only on registered state, never on the inputs.
    assign push_ready_out = (state == READY) && (count < CW'(DEPTH));
    assign top_valid_out  = (state == READY) && (count != '0);
    assign top_out        = tos;
    assign count_out      = count;
    assign underflow_out  = underflow;

    assign push_fire = push_valid_in && push_ready_out;
    assign pop_fire  = pop_ready_in && top_valid_out;

    // A same-cycle push+pop just replaces TOS, so the RAM is only touched by lone operations.
    assign sp       = (count == '0) ? '0 : AW'(count - CW'(1));
    assign ram_we   = push_fire && !pop_fire && (count != '0);
    assign ram_re   = pop_fire && !push_fire && (count >= CW'(2));
    assign ram_addr = ram_we ? sp : (sp - AW'(1));

    x_stack_ram #(
        .X_SIZE(X_SIZE),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_in(clk_in),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (tos),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= READY;
            count     <= '0;
            tos       <= '0;
            underflow <= 1'b0;
        end else begin
            if (state == REFILL) begin
                tos   <= ram_rdata;
                state <= READY;
            end else if (push_fire && pop_fire) begin
                tos <= push_data_in;
            end else if (push_fire) begin
                tos   <= push_data_in;
                count <= count + CW'(1);
            end else if (pop_fire) begin
                count <= count - CW'(1);
                if (count >= CW'(2))
                    state <= REFILL;
            end

            // Sticky so a CPU hung waiting on an empty stack can be diagnosed.
            if ((state == READY) && pop_ready_in && (count == '0))
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_x_stack.sv
// Directed self-checking bench for x_stack with X_SIZE=8, DEPTH=4.
module tb_x_stack;

    logic       clk_in;
    logic       rst_in;
    logic [7:0] push_data_in;
    logic       push_valid_in;
    logic       push_ready_out;
    logic [7:0] top_out;
    logic       top_valid_out;
    logic       pop_ready_in;
    logic [2:0] count_out;
    logic       underflow_out;

    int tests_run;
    int tests_failed;

    x_stack #(
        .X_SIZE(8),
        .DEPTH (4)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .push_data_in  (push_data_in),
        .push_valid_in (push_valid_in),
        .push_ready_out(push_ready_out),
        .top_out       (top_out),
        .top_valid_out (top_valid_out),
        .pop_ready_in  (pop_ready_in),
        .count_out     (count_out),
        .underflow_out (underflow_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        push_valid_in = 1'b0;
        pop_ready_in  = 1'b0;
        push_data_in  = 8'h00;
        rst_in        = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic push_one(input logic [7:0] data);
        @(negedge clk_in);
        push_valid_in = 1'b1;
        push_data_in  = data;
        tick();
        @(negedge clk_in);
        push_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        tests_run++;
        if (count_out !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_count: got %0d expected 0", count_out);
        end
        tests_run++;
        if (top_valid_out !== 1'b0 || push_ready_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_valids: got top_valid=%b push_ready=%b expected 0/1",
                     top_valid_out, push_ready_out);
        end
        tests_run++;
        if (top_out !== 8'h00 || underflow_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_top: got top=%h underflow=%b expected 00/0",
                     top_out, underflow_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        tick();
        tests_run++;
        if (count_out !== 3'd0 || top_valid_out !== 1'b0 || push_ready_out !== 1'b1 || top_out !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL idle_state: got count=%0d tv=%b pr=%b top=%h expected 0/0/1/00",
                     count_out, top_valid_out, push_ready_out, top_out);
        end
    endtask

    task automatic test_fill();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            push_valid_in = 1'b1;
            push_data_in  = vals[i];
            tick();
            tests_run++;
            if (top_out !== vals[i] || top_valid_out !== 1'b1 || count_out !== 3'(i + 1)) begin
                tests_failed++;
                $display("[TB] FAIL fill_step%0d: got top=%h tv=%b count=%0d expected %h/1/%0d",
                         i, top_out, top_valid_out, count_out, vals[i], i + 1);
            end
        end
        tests_run++;
        if (push_ready_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_ready: got %b expected 0", push_ready_out);
        end
        @(negedge clk_in);
        push_data_in = 8'h55;
        tick();
        tick();
        tests_run++;
        if (count_out !== 3'd4 || top_out !== 8'h44) begin
            tests_failed++;
            $display("[TB] FAIL full_stall: got count=%0d top=%h expected 4/44", count_out, top_out);
        end
        @(negedge clk_in);
        push_valid_in = 1'b0;
    endtask

    task automatic test_pop_all();
        logic       exp_tv [8];
        logic [7:0] exp_top [8];
        logic [2:0] exp_cnt [8];
        logic       exp_uf [8];
        exp_tv  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_top = '{8'h44, 8'h33, 8'h33, 8'h22, 8'h22, 8'h11, 8'h11, 8'h11};
        exp_cnt = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
        exp_uf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk_in);
        pop_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (top_valid_out !== exp_tv[i] || top_out !== exp_top[i] ||
                count_out !== exp_cnt[i] || underflow_out !== exp_uf[i]) begin
                tests_failed++;
                $display("[TB] FAIL pop_cycle%0d: got tv=%b top=%h count=%0d uf=%b expected %b/%h/%0d/%b",
                         i, top_valid_out, top_out, count_out, underflow_out,
                         exp_tv[i], exp_top[i], exp_cnt[i], exp_uf[i]);
            end
        end
        @(negedge clk_in);
        pop_ready_in = 1'b0;
        tick();
        tests_run++;
        if (underflow_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL underflow_sticky: got %b expected 1", underflow_out);
        end
    endtask

    task automatic test_push_pop_same();
        do_reset();
        push_one(8'h11);
        push_one(8'h22);
        @(negedge clk_in);
        push_valid_in = 1'b1;
        push_data_in  = 8'hAA;
        pop_ready_in  = 1'b1;
        tick();
        tests_run++;
        if (top_out !== 8'hAA || top_valid_out !== 1'b1 || count_out !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL pushpop_same: got top=%h tv=%b count=%0d expected AA/1/2",
                     top_out, top_valid_out, count_out);
        end
        @(negedge clk_in);
        push_valid_in = 1'b0;
        tick();
        tests_run++;
        if (top_valid_out !== 1'b0 || count_out !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL pushpop_bubble: got tv=%b count=%0d expected 0/1", top_valid_out, count_out);
        end
        @(negedge clk_in);
        pop_ready_in = 1'b0;
        tick();
        tests_run++;
        if (top_out !== 8'h11 || top_valid_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pushpop_refill: got top=%h tv=%b expected 11/1", top_out, top_valid_out);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        push_one(8'h11);
        push_one(8'h22);
        push_one(8'h33);
        push_one(8'h44);
        @(negedge clk_in);
        push_valid_in = 1'b1;
        push_data_in  = 8'h55;
        pop_ready_in  = 1'b1;
        tick();
        tests_run++;
        if (count_out !== 3'd3 || top_valid_out !== 1'b0 || push_ready_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fullpp_pop: got count=%0d tv=%b pr=%b expected 3/0/0",
                     count_out, top_valid_out, push_ready_out);
        end
        @(negedge clk_in);
        pop_ready_in = 1'b0;
        tick();
        tests_run++;
        if (top_out !== 8'h33 || count_out !== 3'd3 || push_ready_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL fullpp_refill: got top=%h count=%0d pr=%b expected 33/3/1",
                     top_out, count_out, push_ready_out);
        end
        tick();
        tests_run++;
        if (top_out !== 8'h55 || count_out !== 3'd4 || top_valid_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL fullpp_push: got top=%h count=%0d tv=%b expected 55/4/1",
                     top_out, count_out, top_valid_out);
        end
        @(negedge clk_in);
        push_valid_in = 1'b0;
        pop_ready_in  = 1'b1;
        tick();
        @(negedge clk_in);
        pop_ready_in = 1'b0;
        tick();
        tests_run++;
        if (top_out !== 8'h33 || count_out !== 3'd3) begin
            tests_failed++;
            $display("[TB] FAIL fullpp_repop: got top=%h count=%0d expected 33/3", top_out, count_out);
        end
    endtask

    task automatic test_reset_refill();
        do_reset();
        push_one(8'h11);
        push_one(8'h22);
        push_one(8'h33);
        @(negedge clk_in);
        pop_ready_in = 1'b1;
        tick();
        tests_run++;
        if (top_valid_out !== 1'b0 || count_out !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL rr_inrefill: got tv=%b count=%0d expected 0/2", top_valid_out, count_out);
        end
        @(negedge clk_in);
        pop_ready_in = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        tests_run++;
        if (count_out !== 3'd0 || top_valid_out !== 1'b0 || underflow_out !== 1'b0 ||
            top_out !== 8'h00 || push_ready_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rr_async: got count=%0d tv=%b uf=%b top=%h pr=%b expected 0/0/0/00/1",
                     count_out, top_valid_out, underflow_out, top_out, push_ready_out);
        end
        tick();
        tests_run++;
        if (top_out !== 8'h00 || count_out !== 3'd0 || top_valid_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rr_discard: got top=%h count=%0d tv=%b expected 00/0/0",
                     top_out, count_out, top_valid_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        push_valid_in = 1'b1;
        push_data_in  = 8'h01;
        tick();
        tests_run++;
        if (top_out !== 8'h01 || count_out !== 3'd1 || top_valid_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rr_push: got top=%h count=%0d tv=%b expected 01/1/1",
                     top_out, count_out, top_valid_out);
        end
        @(negedge clk_in);
        push_valid_in = 1'b0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_in        = 1'b1;
        push_valid_in = 1'b0;
        pop_ready_in  = 1'b0;
        push_data_in  = 8'h00;
        test_reset();
        test_fill();
        test_pop_all();
        test_push_pop_same();
        test_full_push_pop();
        test_reset_refill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
